// File: rtl/au.sv
// Registered adder unit: WIDTH-bit sum of a and b with sign, zero, carry,
// even-parity and signed-overflow flags, one cycle of latency and a valid strobe.
module au #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             s,
  output logic             zr,
  output logic             cy,
  output logic             p,
  output logic             v,
  output logic             out_valid
);

  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH:0]   sum_c;
  logic [WIDTH-1:0] res_c;
  logic             s_c;
  logic             zr_c;
  logic             cy_c;
  logic             p_c;
  logic             v_c;

  // Full-width add with the carry landing in the extra top bit.
  always_comb begin
    sum_c = (WIDTH + 1)'(a) + (WIDTH + 1)'(b);
    res_c = sum_c[WIDTH-1:0];
    cy_c  = sum_c[WIDTH];
    s_c   = res_c[MSB];
    zr_c  = (res_c == '0);
    p_c   = ~^res_c;
    v_c   = (a[MSB] == b[MSB]) && (res_c[MSB] != a[MSB]);
  end

  // Result and flags hold when no operands arrive; only the strobe drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      c         <= '0;
      s         <= 1'b0;
      zr        <= 1'b0;
      cy        <= 1'b0;
      p         <= 1'b0;
      v         <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        c  <= res_c;
        s  <= s_c;
        zr <= zr_c;
        cy <= cy_c;
        p  <= p_c;
        v  <= v_c;
      end
    end
  end

endmodule

// File: tb/tb_au.sv
// Self-checking bench for au: directed vectors plus randomized traffic against
// an integer-arithmetic reference model.
module tb_au;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic         s;
  logic         zr;
  logic         cy;
  logic         p;
  logic         v;
  logic         out_valid;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [W-1:0] m_c;
  logic         m_s, m_zr, m_cy, m_p, m_v, m_ov;

  au #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .c(c), .s(s), .zr(zr), .cy(cy), .p(p), .v(v), .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_edge(input logic r, input logic iv,
                            input logic [W-1:0] xa, input logic [W-1:0] xb);
    int unsigned us;
    int          ss;
    if (r) begin
      m_c = '0; m_s = 0; m_zr = 0; m_cy = 0; m_p = 0; m_v = 0; m_ov = 0;
    end else if (iv) begin
      us   = 32'(xa) + 32'(xb);
      ss   = int'($signed(xa)) + int'($signed(xb));
      m_c  = W'(us % 65536);
      m_cy = (us >= 65536);
      m_s  = (m_c >= 16'h8000);
      m_zr = (m_c == 0);
      m_p  = (($countones(m_c) % 2) == 0);
      m_v  = (ss > 32767) || (ss < -32768);
      m_ov = 1'b1;
    end else begin
      m_ov = 1'b0;
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    checks++;
    assert (c === m_c) else begin
      errors++;
      $error("FAIL %s.c observed=%h expected=%h", tag, c, m_c);
    end
    chk_bit({tag, ".s"}, s, m_s);
    chk_bit({tag, ".zr"}, zr, m_zr);
    chk_bit({tag, ".cy"}, cy, m_cy);
    chk_bit({tag, ".p"}, p, m_p);
    chk_bit({tag, ".v"}, v, m_v);
    chk_bit({tag, ".out_valid"}, out_valid, m_ov);
  endtask

  // Directed check of the sum against a hand-derived constant
  task automatic chk_c(input string tag, input logic [W-1:0] exp);
    checks++;
    assert (c === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, c, exp);
    end
  endtask

  task automatic step(input logic r, input logic iv,
                      input logic [W-1:0] xa, input logic [W-1:0] xb);
    @(negedge clk);
    rst = r; in_valid = iv; a = xa; b = xb;
    @(posedge clk);
    model_edge(r, iv, xa, xb);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    m_c = '0; m_s = 0; m_zr = 0; m_cy = 0; m_p = 0; m_v = 0; m_ov = 0;

    // Reset dominates a valid operand pair
    step(1, 1, 16'hFFFF, 16'h0001); chk_all("reset1");
    step(1, 1, 16'hFFFF, 16'h0001); chk_all("reset2");
    chk_c("reset_c", 16'h0000);
    chk_bit("reset_ov_const", out_valid, 1'b0);

    step(0, 1, 16'h8FFF, 16'h8000); chk_all("ovf");
    chk_c("ovf_c", 16'h0FFF);
    chk_bit("ovf_v_const", v, 1'b1);
    chk_bit("ovf_cy_const", cy, 1'b1);

    step(0, 1, 16'hFFFE, 16'h0002); chk_all("wrap0");
    chk_bit("wrap0_zr_const", zr, 1'b1);
    chk_bit("wrap0_cy_const", cy, 1'b1);

    step(0, 1, 16'hAAAA, 16'h5555); chk_all("ones");
    chk_c("ones_c", 16'hFFFF);

    step(0, 1, 16'h7FFF, 16'h0001); chk_all("posovf");
    chk_c("posovf_c", 16'h8000);
    chk_bit("posovf_p_const", p, 1'b0);
    chk_bit("posovf_v_const", v, 1'b1);

    // Streaming then hold
    step(0, 1, 16'h8FFF, 16'h8000); chk_all("stream0");
    step(0, 1, 16'hFFFE, 16'h0002); chk_all("stream1");
    step(0, 1, 16'hAAAA, 16'h5555); chk_all("stream2");
    step(0, 0, 16'h1234, 16'h4321); chk_all("hold0");
    chk_c("hold0_c", 16'hFFFF);
    step(0, 0, 16'h0000, 16'h0000); chk_all("hold1");

    // Reset mid-stream discards the coincident pair
    step(0, 1, 16'h0001, 16'h0002); chk_all("pre_rst");
    step(1, 1, 16'h1111, 16'h2222); chk_all("mid_rst");
    step(0, 0, 16'h3333, 16'h4444); chk_all("post_rst_idle");
    chk_c("post_rst_c", 16'h0000);
    step(0, 1, 16'h0003, 16'h0004); chk_all("post_rst_first");
    chk_c("post_rst_first_c", 16'h0007);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic         r;
      logic         iv;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      r  = ($urandom_range(0, 31) == 0);
      iv = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0:       begin ra = 16'h8000; rb = W'($urandom); end
        1:       begin ra = 16'h7FFF; rb = W'($urandom_range(0, 3)); end
        2:       begin ra = W'($urandom); rb = W'(~ra + 16'd1); end
        default: begin ra = W'($urandom); rb = W'($urandom); end
      endcase
      step(r, iv, ra, rb);
      chk_all("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/au.md
Name: au

Overview:
- Registered 16-bit adder unit with status flags.
- Adds two unsigned/two's-complement operands and produces the sum plus sign, zero, carry, parity and overflow flags.
- Sits as a leaf arithmetic block inside a datapath; results are registered with a valid strobe so it can be pipelined directly.

Parameters:
- WIDTH, 16, operand/result width in bits (must be >= 2); all flag definitions below refer to bit WIDTH-1 as the MSB.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a/b are valid this cycle; capture and compute.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c  output  WIDTH  registered sum, (a+b) mod 2^WIDTH.
- s  output  1  sign flag = c[WIDTH-1].
- zr  output  1  zero flag = 1 when c == 0.
- cy  output  1  carry out of the MSB of the unsigned add.
- p  output  1  even-parity flag = 1 when c contains an even number of 1 bits (XNOR-reduce of c).
- v  output  1  signed overflow flag.
- out_valid  output  1  c and flags updated from an accepted operand pair this cycle.

Behaviour:
- Reset: rst high at a rising clk edge clears c, s, zr, cy, p, v and out_valid to 0, regardless of in_valid. Reset takes priority over capture.
- Compute: the full sum is {cy, c} = a + b, computed as a WIDTH+1-bit addition with no carry-in.
- Flags are all computed combinationally from the same a, b and sum, then registered alongside c:
  - s = sum[WIDTH-1].
  - zr = (sum[WIDTH-1:0] == 0). zr is independent of cy, so an overflowing add to 0 sets both zr and cy.
  - p = ~^sum[WIDTH-1:0]. p = 1 for zero ones.
  - v = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]), i.e. pos+pos gives neg, or neg+neg gives pos.
- Latency: exactly 1 cycle. Operands presented with in_valid=1 at edge N appear on c/flags with out_valid=1 after edge N.
- in_valid=0 at an edge:
  - c and all flags hold their previous values.
  - out_valid drops to 0 for that cycle.
- Back-to-back: in_valid high on consecutive cycles yields one result per cycle, with no bubbles and no internal state beyond the output registers.
- No backpressure; results are never stalled or dropped.
- All outputs are driven only from registers; no combinational path from a/b to outputs.
- Reset mid-stream: an operand pair presented on the same edge as rst is discarded. The first result after rst deasserts comes from the first subsequent in_valid cycle.
- X-free: outputs are defined from the first reset onward.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1, a=16'hFFFF, b=16'h0001 -> c=0000, s=zr=cy=p=v=0, out_valid=0.
- Overflow: a=16'h8FFF, b=16'h8000, in_valid=1 -> next cycle c=16'h0FFF, s=0, zr=0, cy=1, p=1, v=1, out_valid=1.
- Wrap to zero: a=16'hFFFE, b=16'h0002 -> c=16'h0000, s=0, zr=1, cy=1, p=1, v=0.
- Full ones, no carry: a=16'hAAAA, b=16'h5555 -> c=16'hFFFF, s=1, zr=0, cy=0, p=1, v=0.
- Positive overflow with odd parity: a=16'h7FFF, b=16'h0001 -> c=16'h8000, s=1, zr=0, cy=0, p=0, v=1.
- Hold/streaming:
  - Issue the three vectors 8FFF+8000, FFFE+0002 and AAAA+5555 on consecutive cycles, then drop in_valid.
  - Results appear on consecutive cycles.
  - After in_valid drops, out_valid=0 and c holds 16'hFFFF with its flags unchanged.
